// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port memory between the CPU port (read/write, driven
//   from the MAR/MDR path) and the LCD character fetcher (read-only). One
//   access at a time: IDLE picks a winner and latches its request into the
//   mem_* registers, ACCESS drives the memory enable and the winner's grant,
//   RESP waits for the memory read data, which is returned with an rvalid
//   pulse as the FSM re-enters IDLE.
//
//   Optional feature macro: MEM_ARB_CPU_PRIO_EN
//     undefined : round-robin between the two ports (the port not served last
//                 wins a tie; after reset the CPU wins the first tie).
//     defined   : the CPU wins every tie, except that after STARVE_MAX
//                 consecutive CPU wins over a pending LCD request the next
//                 decision goes to the LCD.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     cpu_req/we/addr/wdata       CPU request (held until cpu_gnt)
//     cpu_gnt, cpu_rvalid         one-cycle pulses
//     cpu_rdata                   CPU read data, held until next cpu_rvalid
//     lcd_req/addr                LCD read request (held until lcd_gnt)
//     lcd_gnt, lcd_rvalid         one-cycle pulses
//     lcd_rdata                   LCD read data, held until next lcd_rvalid
//     mem_addr/wdata/re/we        registered memory controls
//     mem_rdata                   memory data, valid the cycle after mem_re
//     busy                        high while the FSM is in ACCESS or RESP
module mem_port_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 18,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          lcd_req,
  input  logic [AW-1:0] lcd_addr,
  output logic          lcd_gnt,
  output logic          lcd_rvalid,
  output logic [DW-1:0] lcd_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          win_lcd_q, win_lcd_d;   // owner of the access in flight
  logic          is_wr_q, is_wr_d;       // access in flight is a write
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          lcd_gnt_q, lcd_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          lcd_rvalid_q, lcd_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] lcd_rdata_q, lcd_rdata_d;
  logic          busy_q, busy_d;

  logic          pick_lcd;   // arbitration result for the current IDLE cycle
  logic          decide;     // IDLE with at least one request: a decision edge

  assign decide = (state_q == ST_IDLE) && (cpu_req || lcd_req);

`ifdef MEM_ARB_CPU_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  // Counts CPU wins taken while the LCD was also asking.
  logic [CNT_W-1:0] starve_q, starve_d;

  // Fixed CPU priority; once the counter reaches STARVE_MAX the LCD gets the tie.
  always_comb begin
    pick_lcd = 1'b0;
    starve_d = starve_q;
    if (cpu_req && lcd_req) begin
      pick_lcd = (starve_q == CNT_W'(STARVE_MAX));
    end else if (lcd_req) begin
      pick_lcd = 1'b1;
    end else begin
      pick_lcd = 1'b0;
    end
    if (decide) begin
      // Any LCD win, or a decision without LCD demand, ends the starvation run.
      if (pick_lcd || !lcd_req) begin
        starve_d = {CNT_W{1'b0}};
      end else begin
        starve_d = starve_q + CNT_W'(1);
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Last port served; 1 = LCD. Resets to LCD so the CPU wins the first tie.
  logic last_lcd_q, last_lcd_d;

  // Round-robin: a lone request wins; a tie goes to the port not served last.
  always_comb begin
    pick_lcd   = 1'b0;
    last_lcd_d = last_lcd_q;
    if (cpu_req && lcd_req) begin
      pick_lcd = ~last_lcd_q;
    end else if (lcd_req) begin
      pick_lcd = 1'b1;
    end else begin
      pick_lcd = 1'b0;
    end
    if (decide) begin
      last_lcd_d = pick_lcd;
    end else begin
      last_lcd_d = last_lcd_q;
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lcd_q <= 1'b1;
    end else begin
      last_lcd_q <= last_lcd_d;
    end
  end

  // STARVE_MAX only shapes the priority scheme; it has no hardware here.
  if (STARVE_MAX < 1) begin : g_starve_max_inert
  end
`endif

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d      = state_q;
    win_lcd_d    = win_lcd_q;
    is_wr_d      = is_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    lcd_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    lcd_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    lcd_rdata_d  = lcd_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (decide) begin
          // The request is committed here; later req changes do not matter.
          state_d   = ST_ACCESS;
          win_lcd_d = pick_lcd;
          cpu_gnt_d = ~pick_lcd;
          lcd_gnt_d = pick_lcd;
          if (pick_lcd) begin
            is_wr_d     = 1'b0;
            mem_addr_d  = lcd_addr;
            mem_wdata_d = {DW{1'b0}};
            mem_re_d    = 1'b1;
            mem_we_d    = 1'b0;
          end else begin
            is_wr_d     = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_re_d    = ~cpu_we;
            mem_we_d    = cpu_we;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (is_wr_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // mem_rdata is valid now; only the winner's rdata register moves.
        state_d = ST_IDLE;
        if (win_lcd_q) begin
          lcd_rvalid_d = 1'b1;
          lcd_rdata_d  = mem_rdata;
        end else begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_lcd_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      lcd_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      lcd_rvalid_q <= 1'b0;
      cpu_rdata_q  <= {DW{1'b0}};
      lcd_rdata_q  <= {DW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_lcd_q    <= win_lcd_d;
      is_wr_q      <= is_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      lcd_gnt_q    <= lcd_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      lcd_rvalid_q <= lcd_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      lcd_rdata_q  <= lcd_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign lcd_gnt    = lcd_gnt_q;
  assign lcd_rvalid = lcd_rvalid_q;
  assign lcd_rdata  = lcd_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized
// rounds, compared against a transaction-level model of the arbitration
// rules and of the memory contents.
module tb_mem_port_arbiter;
  localparam int AW         = 13;
  localparam int DW         = 18;
  localparam int STARVE_MAX = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          lcd_req;
  logic [AW-1:0] lcd_addr;
  logic          lcd_gnt, lcd_rvalid;
  logic [DW-1:0] lcd_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          init_mem;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr),
    .lcd_gnt(lcd_gnt), .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    if (aa == 13'h1F00) return 18'h00041;
    return {aa[4:0], aa} ^ 18'h15A5A;
  endfunction

  // Environment memory: driven only by the DUT's memory pins.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1 << AW); i++) env_mem[i] <= init_val(i);
    end else begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= env_mem[mem_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] m_cpu_rdata, m_lcd_rdata;
  bit            m_last_lcd;
`ifdef MEM_ARB_CPU_PRIO_EN
  int            m_starve;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_lcd  = 1'b1;
    m_cpu_rdata = '0;
    m_lcd_rdata = '0;
`ifdef MEM_ARB_CPU_PRIO_EN
    m_starve = 0;
`endif
  endtask

  // Winner of one decision, from the arbitration rules.
  task automatic decide(input bit c, input bit l, output bit win_lcd);
    if (c && l) begin
`ifdef MEM_ARB_CPU_PRIO_EN
      win_lcd = (m_starve == STARVE_MAX);
`else
      win_lcd = !m_last_lcd;
`endif
    end else begin
      win_lcd = l;
    end
    m_last_lcd = win_lcd;
`ifdef MEM_ARB_CPU_PRIO_EN
    if (win_lcd || !l) m_starve = 0;
    else m_starve++;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".cpu_gnt"}, cpu_gnt, 0);
    chk({tag, ".cpu_rvalid"}, cpu_rvalid, 0);
    chk({tag, ".cpu_rdata"}, cpu_rdata, 0);
    chk({tag, ".lcd_gnt"}, lcd_gnt, 0);
    chk({tag, ".lcd_rvalid"}, lcd_rvalid, 0);
    chk({tag, ".lcd_rdata"}, lcd_rdata, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_re"}, mem_re, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  // Drive one set of requests (called at a negedge with the FSM idle) and
  // follow every decision it produces. sticky keeps both requests high.
  task automatic serve(input bit c_on, input bit l_on, input bit c_we,
                       input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                       input logic [AW-1:0] l_a, input bit sticky,
                       input int n_dec, input string tag);
    bit c_p, l_p, wl, wr;
    logic [AW-1:0] a;
    int k;
    k = 0;
    cpu_req = c_on; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    lcd_req = l_on; lcd_addr = l_a;
    c_p = c_on; l_p = l_on;
    while ((c_p || l_p) && k < n_dec) begin
      k++;
      decide(c_p, l_p, wl);
      wr = !wl && c_we;
      a  = wl ? l_a : c_a;
      @(negedge clk);  // ACCESS
      chk({tag, ".cpu_gnt"}, cpu_gnt, !wl);
      chk({tag, ".lcd_gnt"}, lcd_gnt, wl);
      chk({tag, ".mem_addr"}, mem_addr, a);
      chk({tag, ".mem_we"}, mem_we, wr);
      chk({tag, ".mem_re"}, mem_re, !wr);
      chk({tag, ".busy_acc"}, busy, 1);
      if (wr) chk({tag, ".mem_wdata"}, mem_wdata, c_d);
      if (!sticky) begin
        // Winner drops req; its fields are scrambled to prove they were latched.
        if (wl) begin
          lcd_req = 1'b0; l_p = 1'b0; lcd_addr = AW'($urandom);
        end else begin
          cpu_req = 1'b0; c_p = 1'b0;
          cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom); cpu_we = 1'($urandom);
        end
      end
      if (wr) begin
        ref_mem[a] = c_d;
        @(negedge clk);  // back in IDLE
        chk({tag, ".wr_busy"}, busy, 0);
        chk({tag, ".wr_we_off"}, mem_we, 0);
        chk({tag, ".wr_gnt_off"}, cpu_gnt, 0);
      end else begin
        @(negedge clk);  // RESP
        chk({tag, ".resp_re_off"}, mem_re, 0);
        chk({tag, ".resp_gnt_off"}, {cpu_gnt, lcd_gnt}, 0);
        chk({tag, ".resp_busy"}, busy, 1);
        chk({tag, ".resp_rvalid"}, {cpu_rvalid, lcd_rvalid}, 0);
        @(negedge clk);  // IDLE with rvalid
        if (wl) m_lcd_rdata = ref_mem[a];
        else m_cpu_rdata = ref_mem[a];
        chk({tag, ".cpu_rvalid"}, cpu_rvalid, !wl);
        chk({tag, ".lcd_rvalid"}, lcd_rvalid, wl);
        chk({tag, ".cpu_rdata"}, cpu_rdata, m_cpu_rdata);
        chk({tag, ".lcd_rdata"}, lcd_rdata, m_lcd_rdata);
        chk({tag, ".rd_busy"}, busy, 0);
      end
    end
    cpu_req = 1'b0;
    lcd_req = 1'b0;
  endtask

  initial begin
    bit wl;
    bit c_on, l_on;
    int sel;
    rst = 1'b1; init_mem = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    lcd_req = 1'b0; lcd_addr = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    model_reset();
    @(negedge clk);
    init_mem = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed: CPU write, LCD read of preloaded word, CPU readback.
    serve(1'b1, 1'b0, 1'b1, 13'h0010, 18'h2ABCD, 13'h0000, 1'b0, 1, "cpu_wr10");
    serve(1'b0, 1'b1, 1'b0, 13'h0000, 18'h00000, 13'h1F00, 1'b0, 1, "lcd_rd1f00");
    chk("lcd_rdata_41", lcd_rdata, 18'h00041);
    chk("cpu_rdata_untouched", cpu_rdata, 18'h00000);
    serve(1'b1, 1'b0, 1'b0, 13'h0010, 18'h00000, 13'h0000, 1'b0, 1, "cpu_rd10");
    chk("cpu_rdata_2abcd", cpu_rdata, 18'h2ABCD);

    // Both ports reading continuously: alternation, or 8 CPU then 1 LCD.
    serve(1'b1, 1'b1, 1'b0, 13'h0010, 18'h00000, 13'h1F00, 1'b1, 20, "contend");

    // Reset during RESP of a CPU read: no rvalid, everything zero.
    decide(1'b1, 1'b0, wl);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1F00;
    @(negedge clk);  // ACCESS
    chk("rstrd.cpu_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    @(negedge clk);  // RESP
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_in_resp");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstrd.no_rvalid", cpu_rvalid, 0);
    serve(1'b1, 1'b0, 1'b0, 13'h1F00, 18'h00000, 13'h0000, 1'b0, 1, "after_rst");

    // Reset on the edge ending a write's ACCESS cycle: the write still lands.
    decide(1'b1, 1'b0, wl);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0020; cpu_wdata = 18'h01234;
    @(negedge clk);  // ACCESS
    chk("rstwr.mem_we", mem_we, 1);
    chk("rstwr.mem_addr", mem_addr, 13'h0020);
    cpu_req = 1'b0;
    rst = 1'b1;
    ref_mem[13'h0020] = 18'h01234;
    @(negedge clk);
    check_all_zero("rst_in_wr");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    serve(1'b1, 1'b0, 1'b0, 13'h0020, 18'h00000, 13'h0000, 1'b0, 1, "rstwr_rd");

    // Randomized rounds over a small address window so reads hit writes.
    for (int r = 0; r < 40; r++) begin
      sel  = $urandom_range(1, 3);
      c_on = sel[0];
      l_on = sel[1];
      serve(c_on, l_on, 1'($urandom),
            13'h0100 + AW'($urandom_range(0, 15)), DW'($urandom),
            13'h0100 + AW'($urandom_range(0, 15)), 1'b0, 2, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
